// File: rtl/tablero_uart_tx.sv
// Serializes tic-tac-toe board snapshots as 12-byte ASCII frames on an 8N1 UART line.
// Latency: tx falls one cycle after a trigger; a frame lasts 120*CLKS_PER_BIT cycles plus a done cycle.
// Backpressure: none accepted; board changes and send requests during a frame coalesce into one follow-up frame.
module tablero_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] winner_player,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [3:0] LAST_BYTE = 4'd11;

  logic [1:0]    state_q, state_d;
  logic [19:0]   snap_q, snap_d;
  logic          pend_q, pend_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [19:0]   live;
  logic [7:0]    cur_char;
  logic          baud_last;

  // Snapshot layout: pos1 in the low bits, winner in the top two bits.
  assign live = {winner_player, pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  function automatic logic [7:0] cell_char(input logic [1:0] c);
    case (c)
      2'b00:   cell_char = 8'h2E; // '.'
      2'b01:   cell_char = 8'h58; // 'X'
      2'b10:   cell_char = 8'h4F; // 'O'
      default: cell_char = 8'h3F; // '?'
    endcase
  endfunction

  function automatic logic [7:0] win_char(input logic [1:0] w);
    case (w)
      2'b00:   win_char = 8'h2D; // '-'
      2'b01:   win_char = 8'h31; // '1'
      2'b10:   win_char = 8'h32; // '2'
      default: win_char = 8'h44; // 'D'
    endcase
  endfunction

  // Select the ASCII character for the byte currently being shifted out.
  always_comb begin
    cur_char = 8'h0A;
    if (byte_q <= 4'd8) begin
      cur_char = cell_char(snap_q[{byte_q, 1'b0} +: 2]);
    end else if (byte_q == 4'd9) begin
      cur_char = win_char(snap_q[19:18]);
    end else if (byte_q == 4'd10) begin
      cur_char = 8'h0D;
    end
  end

  // FSM next-state: trigger evaluation in IDLE, bit timing, and next tx level.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    pend_d    = pend_q | send_req;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    baud_last = (baud_q == BAUD_MAX);

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if ((live != snap_q) || pend_q || send_req) begin
          snap_d  = live;
          pend_d  = 1'b0;
          byte_d  = 4'd0;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = cur_char[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_char[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q == LAST_BYTE) begin
            // The done cycle is itself an IDLE cycle, so a follow-up trigger is seen there.
            state_d = ST_IDLE;
            byte_d  = 4'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 4'd1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      pend_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 4'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tablero_uart_tx.sv
// Directed bench for tablero_uart_tx with CLKS_PER_BIT=4 (40 cycles per byte, 480 per frame).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each frame is recorded cycle by cycle, then checked for exact bit-cell widths and decoded.
module tb_tablero_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] pos [9];
  logic [1:0] win;
  logic       send_req;
  logic       tx, busy, frame_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  localparam logic [95:0] F1 = {"....X....-", 8'h0D, 8'h0A};
  localparam logic [95:0] F2 = {"O...X...O-", 8'h0D, 8'h0A};
  localparam logic [95:0] F3 = {"XXX......1", 8'h0D, 8'h0A};
  localparam logic [95:0] FR = {"XOX......1", 8'h0D, 8'h0A};
  localparam logic [95:0] F4 = {"?????????D", 8'h0D, 8'h0A};

  tablero_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset),
    .pos1(pos[0]), .pos2(pos[1]), .pos3(pos[2]), .pos4(pos[3]), .pos5(pos[4]),
    .pos6(pos[5]), .pos7(pos[6]), .pos8(pos[7]), .pos9(pos[8]),
    .winner_player(win), .send_req(send_req),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count cycles where the line is not idle.
  task automatic quiet(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
  endtask

  // Wait for a start bit, record 480 cycles of tx, then look at the following done cycle.
  task automatic capture(output logic [95:0] s, output int cell_err, output int busy_err,
                         output int first_cyc, output int done_seen, output int done_cyc);
    logic rec [480];
    bit   found;
    int   base;
    found     = 1'b0;
    s         = '0;
    cell_err  = 0;
    busy_err  = 0;
    first_cyc = -1;
    done_seen = 0;
    done_cyc  = -1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    if (!found) begin
      cell_err = 999;
      return;
    end
    first_cyc = cyc;
    rec[0] = tx;
    if (busy !== 1'b1) busy_err++;
    for (int i = 1; i < 480; i++) begin
      @(negedge clk);
      rec[i] = tx;
      if (busy !== 1'b1) busy_err++;
    end
    @(negedge clk);
    done_seen = (frame_done === 1'b1 && busy === 1'b0 && tx === 1'b1) ? 1 : 0;
    done_cyc  = cyc;
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < 10; k++) begin
        base = b * 40 + k * CPB;
        for (int j = 1; j < CPB; j++)
          if (rec[base + j] !== rec[base]) cell_err++;
        if (k == 0 && rec[base] !== 1'b0) cell_err++;
        if (k == 9 && rec[base] !== 1'b1) cell_err++;
        if (k >= 1 && k <= 8) s[(11 - b) * 8 + (k - 1)] = rec[base + 1];
      end
    end
  endtask

  logic [95:0] fr;
  int cerr, berr, fcyc, dseen, dcyc, prev_done, t0, bad, d0;

  initial begin
    reset    = 1'b1;
    send_req = 1'b0;
    win      = 2'b00;
    foreach (pos[i]) pos[i] = 2'b00;

    // Reset state
    tick(3);
    @(negedge clk);
    chk_i("rst_tx", tx, 1);
    chk_i("rst_busy", busy, 0);
    chk_i("rst_done", frame_done, 0);
    tick();
    reset = 1'b0;

    // Empty board, no request: nothing is sent
    quiet(1000, bad);
    chk_i("idle_1000", bad, 0);

    // First frame, with two board changes coalescing into one follow-up
    tick();
    d0 = done_cnt;
    pos[4] = 2'b01;
    t0 = cyc;
    fork
      capture(fr, cerr, berr, fcyc, dseen, dcyc);
      begin
        tick(100);
        pos[0] = 2'b10;
        tick(100);
        pos[8] = 2'b10;
      end
    join
    chk_f("f1_data", fr, F1);
    chk_i("f1_cells", cerr, 0);
    chk_i("f1_busy", berr, 0);
    chk_i("f1_start", fcyc, t0 + 1);
    chk_i("f1_done", dseen, 1);
    chk_i("f1_done_cyc", dcyc, t0 + 481);
    prev_done = dcyc;

    capture(fr, cerr, berr, fcyc, dseen, dcyc);
    chk_f("f2_data", fr, F2);
    chk_i("f2_cells", cerr, 0);
    chk_i("f2_gap", fcyc, prev_done + 1);
    chk_i("f2_done", dseen, 1);
    tick();
    quiet(100, bad);
    chk_i("f2_no_more", bad, 0);
    chk_i("f2_done_count", done_cnt - d0, 2);

    // Winning row plus two send requests mid-frame: one repeat only
    tick();
    pos[0] = 2'b01; pos[1] = 2'b01; pos[2] = 2'b01;
    pos[4] = 2'b00; pos[8] = 2'b00; win = 2'b01;
    t0 = cyc;
    fork
      capture(fr, cerr, berr, fcyc, dseen, dcyc);
      begin
        tick(50);
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        tick(100);
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
      end
    join
    chk_f("f3_data", fr, F3);
    chk_i("f3_cells", cerr, 0);
    chk_i("f3_start", fcyc, t0 + 1);
    prev_done = dcyc;
    capture(fr, cerr, berr, fcyc, dseen, dcyc);
    chk_f("f3_repeat_data", fr, F3);
    chk_i("f3_repeat_gap", fcyc, prev_done + 1);
    chk_i("f3_repeat_done", dseen, 1);
    tick();
    quiet(100, bad);
    chk_i("f3_no_more", bad, 0);

    // Reset mid-frame, with send_req in the same cycle; board cleared during reset
    tick();
    pos[1] = 2'b10;
    t0 = cyc;
    tick(200);
    d0 = done_cnt;
    reset    = 1'b1;
    send_req = 1'b1;
    foreach (pos[i]) pos[i] = 2'b00;
    win = 2'b00;
    tick();
    @(negedge clk);
    chk_i("midrst_tx", tx, 1);
    chk_i("midrst_busy", busy, 0);
    tick();
    reset    = 1'b0;
    send_req = 1'b0;
    quiet(50, bad);
    chk_i("midrst_quiet", bad, 0);
    chk_i("midrst_no_done", done_cnt - d0, 0);

    // Re-apply the interrupted board: a full frame goes out
    tick();
    pos[0] = 2'b01; pos[1] = 2'b10; pos[2] = 2'b01; win = 2'b01;
    t0 = cyc;
    capture(fr, cerr, berr, fcyc, dseen, dcyc);
    chk_f("reapply_data", fr, FR);
    chk_i("reapply_cells", cerr, 0);
    chk_i("reapply_start", fcyc, t0 + 1);
    chk_i("reapply_done", dseen, 1);

    // All cells invalid, draw, with send_req in the same cycle as the change: one frame
    tick();
    foreach (pos[i]) pos[i] = 2'b11;
    win      = 2'b11;
    send_req = 1'b1;
    t0 = cyc;
    tick();
    send_req = 1'b0;
    capture(fr, cerr, berr, fcyc, dseen, dcyc);
    chk_f("f4_data", fr, F4);
    chk_i("f4_cells", cerr, 0);
    chk_i("f4_start", fcyc, t0 + 1);
    chk_i("f4_done_cyc", dcyc, t0 + 481);
    tick();
    quiet(100, bad);
    chk_i("f4_single", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
